// File: rtl/vigenere_stream.sv
// Streaming Vigenere encrypt/decrypt engine: cyclic key from an internal RAM,
// two-stage valid/ready pipeline, per-symbol mode, one symbol per clock.
module vigenere_stream #(
  parameter int unsigned ALPHA       = 26,
  parameter int unsigned SYM_W       = 5,
  parameter int unsigned KEY_MAX_LEN = 16,
  parameter int unsigned IDX_W       = $clog2(KEY_MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_wr_en,
  input  logic [IDX_W-1:0] key_wr_addr,
  input  logic [SYM_W-1:0] key_wr_data,
  output logic             key_wr_err,
  input  logic             cfg_load,
  input  logic [IDX_W:0]   key_len_in,
  input  logic             restart,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_err,
  output logic [IDX_W-1:0] key_idx
);

  localparam logic [SYM_W:0] ALPHA_X = (SYM_W+1)'(ALPHA);
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(KEY_MAX_LEN);
  localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);

  logic [SYM_W-1:0] key_ram [KEY_MAX_LEN];

  logic [IDX_W:0]   key_len;
  logic             s1_valid;
  logic [SYM_W-1:0] s1_data;
  logic [SYM_W-1:0] s1_key;
  logic             s1_mode;

  logic             s1_advance;
  logic             accept;
  logic             s2_load;
  logic             key_wr_ok;
  logic [IDX_W:0]   len_cfg;
  logic [IDX_W:0]   len_now;
  logic [IDX_W:0]   idx_inc;
  logic [IDX_W-1:0] idx_eff;
  logic [IDX_W-1:0] idx_next;

  logic [SYM_W:0]   d_x;
  logic [SYM_W:0]   k_x;
  logic [SYM_W:0]   sum_x;
  logic [SYM_W:0]   res_x;
  logic [SYM_W-1:0] res;
  logic             res_err;

  // Handshake, key-length clamp and key index selection
  always_comb begin
    s1_advance = !out_valid || out_ready;
    in_ready   = !s1_valid || s1_advance;
    accept     = in_valid && in_ready;
    s2_load    = s1_valid && s1_advance;
    key_wr_ok  = key_wr_en && ({1'b0, key_wr_data} < ALPHA_X);

    len_cfg = key_len_in;
    if (key_len_in == '0) begin
      len_cfg = LEN_ONE;
    end else if (key_len_in > LEN_MAX) begin
      len_cfg = LEN_MAX;
    end

    len_now  = cfg_load ? len_cfg : key_len;
    idx_eff  = (restart || cfg_load) ? '0 : key_idx;
    idx_inc  = {1'b0, idx_eff} + LEN_ONE;
    idx_next = idx_eff;
    if (accept) begin
      idx_next = (idx_inc == len_now) ? '0 : idx_inc[IDX_W-1:0];
    end
  end

  // Modular add/subtract by a single conditional correction
  always_comb begin
    d_x     = {1'b0, s1_data};
    k_x     = {1'b0, s1_key};
    sum_x   = d_x + k_x;
    res_err = (d_x >= ALPHA_X);
    res_x   = '0;
    if (!s1_mode) begin
      res_x = (sum_x >= ALPHA_X) ? (sum_x - ALPHA_X) : sum_x;
    end else begin
      res_x = (d_x >= k_x) ? (d_x - k_x) : (d_x + ALPHA_X - k_x);
    end
    res = res_err ? s1_data : res_x[SYM_W-1:0];
  end

  // Key RAM has no reset; an accept in the same cycle reads the old word
  always_ff @(posedge clk) begin
    if (key_wr_ok) begin
      key_ram[key_wr_addr] <= key_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_wr_err <= 1'b0;
      key_len    <= LEN_ONE;
      key_idx    <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_key     <= '0;
      s1_mode    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
    end else begin
      key_wr_err <= key_wr_en && !key_wr_ok;
      if (cfg_load) begin
        key_len <= len_cfg;
      end
      key_idx <= idx_next;

      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_mode  <= in_mode;
        s1_key   <= key_ram[idx_eff];
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_err   <= res_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vigenere_stream.sv
// Bench for vigenere_stream: cycle-by-cycle comparison against a queue-based
// capacity-2 pipeline model using modulo arithmetic, plus literal result checks.
module tb_vigenere_stream;

  localparam int ALPHA = 26;
  localparam int KMAX  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_wr_en;
  logic [3:0] key_wr_addr;
  logic [4:0] key_wr_data;
  logic       key_wr_err;
  logic       cfg_load;
  logic [4:0] key_len_in;
  logic       restart;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_data;
  logic       out_err;
  logic [3:0] key_idx;

  vigenere_stream dut (
    .clk(clk), .reset(reset),
    .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
    .key_wr_err(key_wr_err),
    .cfg_load(cfg_load), .key_len_in(key_len_in), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .key_idx(key_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit err;
    int acc;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  int   mkey[KMAX];
  int   mlen = 1;
  int   midx = 0;
  bit   m_wr_err = 0;
  bit   last_acc = 0;
  int   cyc = 0;
  int   got[$];
  bit   got_err[$];
  int   exp_q[$];
  bit   rand_or = 0;
  bit   or_fixed = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int model_sym(int d, int k, bit dec);
    if (d >= ALPHA) return d;
    return dec ? (d - k + ALPHA) % ALPHA : (d + k) % ALPHA;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rand_or ? 1'($urandom_range(0, 1)) : or_fixed;
  end

  // Compare DUT against the model, then advance the model for the coming edge
  always @(negedge clk) begin
    if (reset) begin
      bit   exp_valid;
      bit   exp_rdy;
      bit   acc;
      int   len_now;
      int   idx_eff;
      ent_t e;
      exp_valid = (q.size() > 0) && (q[0].acc + 2 <= cyc);
      exp_rdy   = (q.size() < 2) || out_ready;
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid && out_valid) begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_err", 32'(out_err), 32'(q[0].err));
      end
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("key_idx", 32'(key_idx), 32'(midx));
      chk("key_wr_err", 32'(key_wr_err), 32'(m_wr_err));

      if (exp_valid && out_ready) begin
        got.push_back(int'(out_data));
        got_err.push_back(out_err);
        void'(q.pop_front());
      end
      len_now = mlen;
      if (cfg_load) len_now = (key_len_in == 0) ? 1 : (int'(key_len_in) > KMAX ? KMAX : int'(key_len_in));
      idx_eff = (restart || cfg_load) ? 0 : midx;
      acc = in_valid && exp_rdy;
      if (acc) begin
        e.data = model_sym(int'(in_data), mkey[idx_eff], in_mode);
        e.err  = (int'(in_data) >= ALPHA);
        e.acc  = cyc;
        q.push_back(e);
        midx = (idx_eff + 1) % len_now;
      end else begin
        midx = idx_eff;
      end
      mlen     = len_now;
      last_acc = acc;
      m_wr_err = key_wr_en && (int'(key_wr_data) >= ALPHA);
      if (key_wr_en && int'(key_wr_data) < ALPHA) mkey[key_wr_addr] = int'(key_wr_data);
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit m, input bit rs);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = 5'(d);
    in_mode  = m;
    restart  = rs;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      key_wr_en = 1'b0;
      if (last_acc) done = 1;
    end
    in_valid = 1'b0;
    restart  = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_key(input int a, input int d);
    key_wr_en   = 1'b1;
    key_wr_addr = 4'(a);
    key_wr_data = 5'(d);
    tick();
    key_wr_en = 1'b0;
  endtask

  task automatic cfg(input int len);
    cfg_load   = 1'b1;
    key_len_in = 5'(len);
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic drain();
    bit empty = 0;
    rand_or  = 0;
    or_fixed = 1;
    for (int i = 0; i < 40 && !empty; i++) begin
      tick();
      if (q.size() == 0) empty = 1;
    end
    if (!empty) chk("drain_timeout", 32'(q.size()), 32'd0);
    tick();
  endtask

  task automatic clear_got();
    got.delete();
    got_err.delete();
  endtask

  task automatic check_seq(input string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nm, 32'(got[i]), 32'(exp_q[i]));
    clear_got();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b0;
    q.delete();
    midx = 0; mlen = 1; m_wr_err = 0; last_acc = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_key_idx", 32'(key_idx), 32'd0);
    tick();
    reset = 1'b1;
  endtask

  int lemon[5]  = '{11, 4, 12, 14, 13};
  int attack[12] = '{0, 19, 19, 0, 2, 10, 0, 19, 3, 0, 22, 13};
  int cipher[12] = '{11, 23, 5, 14, 15, 21, 4, 5, 17, 13, 7, 17};

  initial begin
    reset = 1'b0; key_wr_en = 0; key_wr_addr = 0; key_wr_data = 0;
    cfg_load = 0; key_len_in = 0; restart = 0; in_valid = 0; in_data = 0; in_mode = 0;
    for (int i = 0; i < KMAX; i++) mkey[i] = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_key_wr_err", 32'(key_wr_err), 32'd0);
    chk("rst_key_idx", 32'(key_idx), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    tick();

    for (int i = 0; i < KMAX; i++) write_key(i, (i < 5) ? lemon[i] : (i * 7 + 3) % ALPHA);
    cfg(5);

    // LEMON / ATTACKATDAWN encrypt, back-to-back
    clear_got();
    for (int i = 0; i < 12; i++) send(attack[i], 1'b0, 1'b0);
    drain();
    exp_q = '{11, 23, 5, 14, 15, 21, 4, 5, 17, 13, 7, 17};
    check_seq("lemon_enc");

    // Decrypt back to plaintext after a standalone restart
    pulse_restart();
    for (int i = 0; i < 12; i++) send(cipher[i], 1'b1, 1'b0);
    drain();
    exp_q = '{0, 19, 19, 0, 2, 10, 0, 19, 3, 0, 22, 13};
    check_seq("lemon_dec");

    // Out-of-range symbol consumes a key position
    pulse_restart();
    send(0, 1'b0, 1'b0); send(30, 1'b0, 1'b0); send(0, 1'b0, 1'b0);
    drain();
    if (got_err.size() == 3) begin
      chk("oor_err_flag", 32'(got_err[1]), 32'd1);
      chk("oor_neighbour_err", 32'(got_err[2]), 32'd0);
    end
    exp_q = '{11, 30, 12};
    check_seq("oor_seq");

    // Restart on an accept cycle uses key[0]
    send(3, 1'b0, 1'b0);
    send(19, 1'b0, 1'b1);
    drain();
    chk("restart_idx", 32'(key_idx), 32'd1);
    exp_q = '{17, 4};
    check_seq("restart_seq");

    // key_len 0 clamps to 1
    cfg(0);
    send(0, 1'b0, 1'b0); send(0, 1'b0, 1'b0); send(0, 1'b0, 1'b0);
    drain();
    exp_q = '{11, 11, 11};
    check_seq("len0_seq");

    // Alphabet edges and rejected key write
    write_key(0, 25);
    cfg(1);
    send(25, 1'b0, 1'b0);
    write_key(0, 1);
    send(0, 1'b1, 1'b0);
    write_key(0, 26);
    chk("wr_err_pulse", 32'(key_wr_err), 32'd1);
    send(0, 1'b1, 1'b0);
    drain();
    exp_q = '{24, 25, 25};
    check_seq("edge_seq");

    // key_len 20 clamps to 16
    write_key(0, 11);
    cfg(20);
    for (int i = 0; i < 17; i++) send(0, 1'b0, 1'b0);
    drain();
    chk("len20_wrap_idx", 32'(key_idx), 32'd1);
    if (got.size() == 17) chk("len20_wrap_key0", 32'(got[16]), 32'd11);
    clear_got();

    // Randomised traffic under random backpressure
    cfg(5);
    rand_or = 1;
    for (int n = 0; n < 200; n++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) cfg($urandom_range(0, 31));
      if (r == 1) write_key($urandom_range(0, 15), $urandom_range(0, 31));
      if (r == 2) begin
        key_wr_en   = 1'b1;
        key_wr_addr = 4'($urandom_range(0, 15));
        key_wr_data = 5'($urandom_range(0, 25));
      end
      if ($urandom_range(0, 3) == 0) tick();
      send(($urandom_range(0, 9) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    drain();
    clear_got();

    // Reset with two symbols in flight
    rand_or  = 0;
    or_fixed = 0;
    tick();
    send(5, 1'b0, 1'b0);
    send(6, 1'b0, 1'b0);
    chk("inflight_two", 32'(q.size()), 32'd2);
    do_reset();
    or_fixed = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("post_reset_no_output", 32'(got.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vigenere_stream.md
Name: vigenere_stream

Overview:
Parametrised streaming Vigenère encrypt/decrypt engine. Symbols are integers in the range 0..ALPHA-1. A key of 1..KEY_MAX_LEN symbols is held in an internal key RAM and applied cyclically. Symbols flow through a 2-stage valid/ready pipeline at one symbol per clock. The mode (encrypt or decrypt) is selected per symbol. The block sits between the symbol source (a UART/byte-to-symbol mapper) and the sink in the encryption datapath.

Parameters:
ALPHA, 26, alphabet size (2..2**SYM_W)
SYM_W, 5, symbol width in bits
KEY_MAX_LEN, 16, key RAM depth (power of 2, >=2)
IDX_W, $clog2(KEY_MAX_LEN), key index width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
key_wr_en  in  1  write one key symbol this cycle
key_wr_addr  in  IDX_W  key RAM address
key_wr_data  in  SYM_W  key symbol
key_wr_err  out  1  registered 1-cycle pulse: write rejected because key_wr_data >= ALPHA
cfg_load  in  1  latch key_len_in and restart the key index
key_len_in  in  IDX_W+1  active key length
restart  in  1  restart the key index at 0
in_valid  in  1  input symbol valid
in_ready  out  1  block can accept a symbol
in_data  in  SYM_W  input symbol
in_mode  in  1  0 = encrypt, 1 = decrypt; travels with the symbol
out_valid  out  1  output symbol valid
out_ready  in  1  sink accepts output
out_data  out  SYM_W  result symbol
out_err  out  1  input symbol was >= ALPHA; data passed through unchanged
key_idx  out  IDX_W  key index that the next accepted symbol will use

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid, out_data, out_err, key_wr_err, key_idx, and both stage valid flags go to 0.
  - key_len goes to 1.
  - Key RAM contents are not reset; the bench must load the key before traffic.
- Key write:
  - When key_wr_en=1 and key_wr_data < ALPHA, the RAM word is written at the clock edge.
  - Otherwise the word is unchanged and key_wr_err=1 on the next cycle.
  - A written key is used by symbols accepted on later cycles. A same-cycle write and accept uses the old word.
- Key length:
  - cfg_load latches key_len_in. A value of 0 or greater than KEY_MAX_LEN clamps to 1 and KEY_MAX_LEN respectively.
  - cfg_load also forces key_idx to 0.
- Input handshake:
  - A symbol is accepted when in_valid && in_ready.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready (no combinational path from in_valid).
  - On accept, stage 1 captures in_data, in_mode, and key[idx_eff].
- Key index:
  - idx_eff = 0 if restart || cfg_load this cycle; otherwise idx_eff = key_idx.
  - After an accept, key_idx <= (idx_eff+1 == key_len) ? 0 : idx_eff+1. The new key_len applies to the wrap on a cfg_load cycle.
  - With no accept, key_idx <= restart||cfg_load ? 0 : key_idx.
- Out-of-range symbols: a symbol >= ALPHA still consumes a key position (the index advances). out_err=1 and out_data=in_data.
- Stage 2 arithmetic (registered into out_data):
  - Encrypt: s = d + k on SYM_W+1 bits; result = s >= ALPHA ? s - ALPHA : s.
  - Decrypt: result = d >= k ? d - k : d + ALPHA - k.
  - No % or / operator is used.
- Output handshake:
  - Stage 2 loads when s1_valid && (!out_valid || out_ready).
  - out_valid/out_data/out_err hold stable while out_valid && !out_ready.
- Latency and throughput:
  - Accept to out_valid is 2 cycles.
  - Sustained 1 symbol/cycle when out_ready=1.
  - Under backpressure the pipeline holds at most 2 symbols; in_ready drops when both stages are full and out_ready=0.
- Mode: mode switches mid-stream apply per symbol, with no bubble.
- Reset mid-stream drops in-flight symbols. No output follows until new input arrives.

Test Plan:
- Key LEMON (11,4,12,14,13), key_len 5, encrypt ATTACKATDAWN (0,19,19,0,2,10,0,19,3,0,22,13) streamed back-to-back with out_ready=1 -> out 11,23,5,14,15,21,4,5,17,13,7,17 one per cycle; first out_valid 2 cycles after first accept.
- Same stream in decrypt mode with restart before the first symbol -> ATTACKATDAWN recovered; key_idx sequence 0,1,2,3,4,0,...
- Encrypt data 25 with key 25 -> 24; decrypt data 0 with key 1 -> 25; key_wr_data 26 -> key_wr_err pulse, RAM word unchanged.
- out_ready toggled pseudo-randomly over 200 random symbols -> no loss or duplication; in_ready=0 only when both stages are full; outputs stable while stalled; results match the reference model.
- in_data 30 mid-stream -> out_err=1, out_data=30, and the next symbol uses the following key index; restart asserted on an accept cycle -> that symbol uses key[0] and key_idx becomes 1.
- cfg_load key_len_in 0 -> key length 1 (key[0] repeated); key_len_in 20 with KEY_MAX_LEN=16 -> wraps after 16; reset asserted with 2 symbols in flight -> out_valid=0 immediately and no stale output afterwards.
